// File: rtl/router_input_port.sv
// Mesh router input port: an even and an odd single-entry VC buffer.
// The XY route is computed as each flit is written, and polarity selects which VC is presented.
module router_input_port #(
   parameter logic [3:0] X_POS      = 4'd0,
   parameter logic [3:0] Y_POS      = 4'd0,
   parameter int         DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  polarity,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [1:0]            in_ready,
   output logic [4:0]            req,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  gnt,
   output logic                  err
);

   logic [1:0]            valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q  [2];
   logic [DATA_WIDTH-1:0] data_d  [2];
   logic [4:0]            route_q [2];
   logic [4:0]            route_d [2];
   logic                  err_q, err_d;
   logic                  in_vc;

   // Route bit order is {UP, DOWN, LEFT, RIGHT, PE}; X is resolved before Y.
   function automatic logic [4:0] xy_route(input logic [3:0] dest_x, input logic [3:0] dest_y);
      logic [4:0] r;
      if (dest_x > X_POS)      r = 5'b00010;
      else if (dest_x < X_POS) r = 5'b00100;
      else if (dest_y > Y_POS) r = 5'b10000;
      else if (dest_y < Y_POS) r = 5'b01000;
      else                     r = 5'b00001;
      return r;
   endfunction

   assign in_vc = in_data[63];

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      route_d = route_q;
      err_d   = err_q;
      if (in_valid && !valid_q[in_vc]) begin
         valid_d[in_vc] = 1'b1;
         data_d[in_vc]  = in_data;
         route_d[in_vc] = xy_route(in_data[51:48], in_data[47:44]);
      end
      // A write to a VC requires it empty and a grant requires it full, so the two never collide.
      if (gnt) begin
         if (valid_q[polarity]) valid_d[polarity] = 1'b0;
         else                   err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 2'b00;
         data_q[0]  <= '0;
         data_q[1]  <= '0;
         route_q[0] <= 5'b00000;
         route_q[1] <= 5'b00000;
         err_q      <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         route_q <= route_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = ~valid_q;
   assign req      = valid_q[polarity] ? route_q[polarity] : 5'b00000;
   assign out_data = data_q[polarity];
   assign err      = err_q;

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port placed at mesh node (1,1).
// It uses hand-computed route, ready and error expectations.
module tb_router_input_port;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          polarity;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    in_ready;
   logic [4:0]    req;
   logic [DW-1:0] out_data;
   logic          gnt;
   logic          err;

   int checks_total  = 0;
   int checks_passed = 0;

   router_input_port #(.X_POS(4'd1), .Y_POS(4'd1), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .polarity (polarity),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .req      (req),
      .out_data (out_data),
      .gnt      (gnt),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mkFlit(input logic vc, input logic [3:0] dx,
                                             input logic [3:0] dy, input logic [15:0] tag);
      logic [DW-1:0] f;
      f        = '0;
      f[63]    = vc;
      f[51:48] = dx;
      f[47:44] = dy;
      f[15:0]  = tag;
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Drives one cycle of inputs, samples them at the edge, then idles the handshakes.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic g);
      in_valid = v;
      in_data  = d;
      gnt      = g;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      gnt      = 1'b0;
   endtask

   logic [DW-1:0] flit_a, flit_b, flit_c, flit_d, flit_e, flit_f, flit_g;

   initial begin
      flit_a = mkFlit(1'b0, 4'd3,  4'd1,  16'hA0A0);
      flit_b = mkFlit(1'b0, 4'd0,  4'd1,  16'hB0B0);
      flit_c = mkFlit(1'b0, 4'd1,  4'd2,  16'hC0C0);
      flit_d = mkFlit(1'b1, 4'd1,  4'd1,  16'hD0D0);
      flit_e = mkFlit(1'b0, 4'd1,  4'd0,  16'hE0E0);
      flit_f = mkFlit(1'b0, 4'd15, 4'd0,  16'hF0F0);
      flit_g = mkFlit(1'b1, 4'd1,  4'd15, 16'h1234);

      reset = 1'b1; polarity = 1'b0; in_valid = 1'b0; in_data = '0; gnt = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
      checkOutput("reset_in_ready", 64'(in_ready), 64'(2'b11));
      checkOutput("reset_req",      64'(req),      64'(5'b00000));
      checkOutput("reset_err",      64'(err),      64'(1'b0));

      // Even flit to (3,1) heads RIGHT.
      applyStimulus(1'b1, flit_a, 1'b0);
      checkOutput("write_req_right", 64'(req),      64'(5'b00010));
      checkOutput("write_in_ready",  64'(in_ready), 64'(2'b10));
      checkOutput("write_out_data",  out_data,      flit_a);

      // A second even flit into the full buffer is ignored.
      applyStimulus(1'b1, flit_b, 1'b0);
      checkOutput("full_keep_data", out_data,      flit_a);
      checkOutput("full_in_ready",  64'(in_ready), 64'(2'b10));
      checkOutput("full_keep_req",  64'(req),      64'(5'b00010));
      checkOutput("full_no_err",    64'(err),      64'(1'b0));

      // A grant frees the even buffer, and it accepts a new flit the next cycle.
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("gnt_in_ready", 64'(in_ready), 64'(2'b11));
      checkOutput("gnt_req_zero", 64'(req),      64'(5'b00000));
      applyStimulus(1'b1, flit_c, 1'b0);
      checkOutput("rewrite_req_up",   64'(req),      64'(5'b10000));
      checkOutput("rewrite_in_ready", 64'(in_ready), 64'(2'b10));

      // An odd write and an even grant in the same cycle both take effect.
      applyStimulus(1'b1, flit_d, 1'b1);
      checkOutput("concurrent_in_ready", 64'(in_ready), 64'(2'b01));
      checkOutput("concurrent_req_even", 64'(req),      64'(5'b00000));
      checkOutput("concurrent_err",      64'(err),      64'(1'b0));
      polarity = 1'b1;
      #1;
      checkOutput("odd_req_pe",   64'(req), 64'(5'b00001));
      checkOutput("odd_out_data", out_data, flit_d);

      // With both VCs full, polarity switches the presented buffer combinationally.
      applyStimulus(1'b1, flit_e, 1'b0);
      polarity = 1'b0;
      #1;
      checkOutput("pol0_req_down", 64'(req), 64'(5'b01000));
      checkOutput("pol0_out_data", out_data, flit_e);
      polarity = 1'b1;
      #1;
      checkOutput("pol1_req_pe", 64'(req), 64'(5'b00001));

      // Compare unsigned coordinates: dest_x 15 is east of column 1.
      polarity = 1'b0;
      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b1, flit_f, 1'b0);
      checkOutput("unsigned_x_right", 64'(req), 64'(5'b00010));

      // Reset drops both full buffers, and the grant in the same cycle is discarded.
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);
      reset = 1'b0;
      checkOutput("rst_full_req_pol0", 64'(req),      64'(5'b00000));
      polarity = 1'b1;
      #1;
      checkOutput("rst_full_req_pol1", 64'(req),      64'(5'b00000));
      checkOutput("rst_full_in_ready", 64'(in_ready), 64'(2'b11));
      checkOutput("rst_full_err",      64'(err),      64'(1'b0));

      // A write presented during reset is discarded.
      reset = 1'b1;
      applyStimulus(1'b1, flit_g, 1'b0);
      reset = 1'b0;
      checkOutput("rst_write_in_ready", 64'(in_ready), 64'(2'b11));
      checkOutput("rst_write_req",      64'(req),      64'(5'b00000));

      // Compare unsigned coordinates: dest_y 15 is north of row 1 (odd VC, polarity 1).
      applyStimulus(1'b1, flit_g, 1'b0);
      checkOutput("unsigned_y_up", 64'(req), 64'(5'b10000));

      // A grant to an empty active buffer sets a sticky error and leaves the buffers alone.
      polarity = 1'b0;
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("err_set",        64'(err),      64'(1'b1));
      checkOutput("err_buffers",    64'(in_ready), 64'(2'b01));
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("err_sticky",     64'(err),      64'(1'b1));
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
      checkOutput("err_cleared",    64'(err),      64'(1'b0));
      checkOutput("err_rst_ready",  64'(in_ready), 64'(2'b11));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
